sequenciador_venda: RTL

//  Vending sequence controller. Collects a two-digit product code from the keypad,

---
 rtl/sequenciador_venda_if.sv | 28 ++
 rtl/sequenciador_venda.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_venda_if.sv
// rtl/sequenciador_venda_if.sv - keypad, coin, lookup and sale-status bundle for the vending sequencer
interface sequenciador_venda_if;
    logic       tecla_valida;
    logic [3:0] tecla;
    logic       moeda_valida;
    logic [1:0] moeda_valor;
    logic       produto_existe;
    logic [3:0] preco;
    logic [7:0] codigo;
    logic [3:0] credito;
    logic [1:0] estado;
    logic       liberar;
    logic       devolver;
    logic [3:0] troco;
    logic       erro;

    // front-ends and lookup memory side
    modport master (
        output tecla_valida, tecla, moeda_valida, moeda_valor, produto_existe, preco,
        input  codigo, credito, estado, liberar, devolver, troco, erro
    );

    // sequencer side
    modport slave (
        input  tecla_valida, tecla, moeda_valida, moeda_valor, produto_existe, preco,
        output codigo, credito, estado, liberar, devolver, troco, erro
    );
endinterface

// File: rtl/sequenciador_venda.sv
// rtl/sequenciador_venda.sv - vending sequence controller (code entry, credit, dispense, change); TROCO_EN enables change return after dispense
module sequenciador_venda #(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int LIBERA_CICLOS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sequenciador_venda_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam int LW = (LIBERA_CICLOS > 1) ? $clog2(LIBERA_CICLOS) : 1;

    typedef enum logic [2:0] {
        OCIOSO,
        DIGITO,
        VERIFICA,
        PAGAMENTO,
        LIBERA,
        DEVOLVE,
        CANCELA
    } fase_t;

    fase_t          fase_q, fase_d;
    logic [7:0]     codigo_q, codigo_d;
    logic [3:0]     credito_q, credito_d;
    logic [3:0]     troco_q, troco_d;
    logic [1:0]     estado_q, estado_d;
    logic           liberar_q, liberar_d;
    logic           devolver_q, devolver_d;
    logic           erro_q, erro_d;
    logic [TW-1:0]  tempo_q, tempo_d;
    logic [LW-1:0]  libera_cnt_q, libera_cnt_d;

    logic           eh_digito;
    logic           eh_cancela;
    logic           moeda_aceita;
    logic           atividade;
    logic           expirou;
    logic [4:0]     soma;
    logic [3:0]     credito_mais;

    // decode of this cycle's keypad/coin activity and the saturated credit sum
    always_comb begin
        eh_digito    = bus.tecla_valida && (bus.tecla <= 4'd9);
        eh_cancela   = bus.tecla_valida && (bus.tecla == 4'hA);
        moeda_aceita = bus.moeda_valida && (bus.moeda_valor != 2'd0) &&
                       ((fase_q == OCIOSO) || (fase_q == DIGITO) ||
                        (fase_q == VERIFICA) || (fase_q == PAGAMENTO));
        atividade    = bus.tecla_valida || moeda_aceita;
        expirou      = (tempo_q == TW'(TIMEOUT_CICLOS - 1));
        soma         = {1'b0, credito_q} + {3'b000, bus.moeda_valor};
        credito_mais = moeda_aceita ? (soma[4] ? 4'hF : soma[3:0]) : credito_q;
    end

    // next-state and registered-output computation
    always_comb begin
        fase_d       = fase_q;
        codigo_d     = codigo_q;
        credito_d    = credito_q;
        troco_d      = troco_q;
        erro_d       = 1'b0;
        libera_cnt_d = libera_cnt_q;

        case (fase_q)
            OCIOSO: begin
                credito_d = credito_mais;
                if (eh_digito) begin
                    codigo_d[7:4] = bus.tecla;
                    fase_d        = DIGITO;
                end
            end
            DIGITO: begin
                credito_d = credito_mais;
                if (eh_digito) begin
                    codigo_d[3:0] = bus.tecla;
                    fase_d        = VERIFICA;
                end else if (eh_cancela) begin
                    fase_d = CANCELA;
                end else if (!atividade && expirou) begin
                    fase_d = CANCELA;
                end
            end
            VERIFICA: begin
                credito_d = credito_mais;
                if (!bus.produto_existe) begin
                    erro_d   = 1'b1;
                    codigo_d = 8'h00;
                    fase_d   = OCIOSO;
                end else begin
                    fase_d = PAGAMENTO;
                end
            end
            PAGAMENTO: begin
                credito_d = credito_mais;
                // a cancel press wins over a sale that becomes payable in the same cycle
                if (eh_cancela) begin
                    fase_d = CANCELA;
                end else if (credito_q >= bus.preco) begin
                    fase_d = LIBERA;
                end else if (!atividade && expirou) begin
                    fase_d = CANCELA;
                end
            end
            LIBERA: begin
                libera_cnt_d = libera_cnt_q + LW'(1);
                if (libera_cnt_q == LW'(LIBERA_CICLOS - 1)) begin
                    libera_cnt_d = '0;
                    codigo_d     = 8'h00;
`ifdef TROCO_EN
                    troco_d   = credito_q - bus.preco;
                    credito_d = 4'h0;
                    fase_d    = (credito_q != bus.preco) ? DEVOLVE : OCIOSO;
`else
                    credito_d = credito_q - bus.preco;
                    fase_d    = OCIOSO;
`endif
                end
            end
            DEVOLVE: begin
                troco_d = 4'h0;
                fase_d  = OCIOSO;
            end
            CANCELA: begin
                codigo_d = 8'h00;
                if (credito_q != 4'h0) begin
                    troco_d   = credito_q;
                    credito_d = 4'h0;
                    fase_d    = DEVOLVE;
                end else begin
                    fase_d = OCIOSO;
                end
            end
            default: begin
                fase_d = OCIOSO;
            end
        endcase

        // idle timer restarts on every state change and on any key or accepted coin
        tempo_d = tempo_q;
        if ((fase_d != fase_q) || atividade) begin
            tempo_d = '0;
        end else if (((fase_q == DIGITO) || (fase_q == PAGAMENTO)) && !expirou) begin
            tempo_d = tempo_q + TW'(1);
        end

        case (fase_d)
            DIGITO, VERIFICA: estado_d = 2'd1;
            PAGAMENTO:        estado_d = 2'd2;
            LIBERA:           estado_d = 2'd3;
            default:          estado_d = 2'd0;
        endcase
        liberar_d  = (fase_d == LIBERA);
        devolver_d = (fase_d == DEVOLVE);
    end

    // state and output registers; reset drops any pending credit silently
    always_ff @(posedge clk) begin
        if (reset) begin
            fase_q       <= OCIOSO;
            codigo_q     <= 8'h00;
            credito_q    <= 4'h0;
            troco_q      <= 4'h0;
            estado_q     <= 2'd0;
            liberar_q    <= 1'b0;
            devolver_q   <= 1'b0;
            erro_q       <= 1'b0;
            tempo_q      <= '0;
            libera_cnt_q <= '0;
        end else begin
            fase_q       <= fase_d;
            codigo_q     <= codigo_d;
            credito_q    <= credito_d;
            troco_q      <= troco_d;
            estado_q     <= estado_d;
            liberar_q    <= liberar_d;
            devolver_q   <= devolver_d;
            erro_q       <= erro_d;
            tempo_q      <= tempo_d;
            libera_cnt_q <= libera_cnt_d;
        end
    end

    assign bus.codigo   = codigo_q;
    assign bus.credito  = credito_q;
    assign bus.troco    = troco_q;
    assign bus.estado   = estado_q;
    assign bus.liberar  = liberar_q;
    assign bus.devolver = devolver_q;
    assign bus.erro     = erro_q;
endmodule
